register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 98 +++++++++
 tb/tb_register_file.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 2**ADDR_WIDTH x DATA_WIDTH general-purpose register file.
//                Two combinational (zero-latency) read ports and one
//                synchronous write port.
//
//                Entry 0 (x0) is hard-wired to zero.
//
//                Asynchronous active-low reset clears every entry
//                immediately.
//
//                Optional feature, selected by the macro REGFILE_BYPASS_EN:
//                - Defined: a same-cycle write to the index being read is
//                  forwarded to that read port (write-through).
//                - Undefined (default): reads return the stored,
//                  pre-edge value.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1           clock, writes on rising edge
//    rst        in   1           asynchronous reset, active-low
//    rs1        in   ADDR_WIDTH  read port 1 index
//    rs2        in   ADDR_WIDTH  read port 2 index
//    rd         in   ADDR_WIDTH  write port index
//    rd_data    in   DATA_WIDTH  write data
//    rd_enable  in   1           write enable, active-high
//    rs1_data   out  DATA_WIDTH  read port 1 data
//    rs2_data   out  DATA_WIDTH  read port 2 data
// ============================================================================
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_enable,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] w_we;
    logic [DATA_WIDTH-1:0] w_rs1_stored;
    logic [DATA_WIDTH-1:0] w_rs2_stored;

    // Write-enable decode. Bit 0 is never set, so x0 holds its reset value
    // of zero forever and writes to rd=0 are silently dropped.
    always_comb begin
        w_we = '0;
        if (rd_enable && (rd != '0)) begin
            w_we[rd] = 1'b1;
        end
    end

    // One flop bank per entry; reset has priority over a coincident write
    // edge, so writes while rst=0 never land.
    generate
        for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_regs
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_regs[gi] <= '0;
                end else if (w_we[gi]) begin
                    r_regs[gi] <= rd_data;
                end
            end
        end
    endgenerate

    // Stored-value read. The explicit zero for index 0 keeps x0 reading
    // zero independent of the flop contents.
    assign w_rs1_stored = (rs1 == '0) ? '0 : r_regs[rs1];
    assign w_rs2_stored = (rs2 == '0) ? '0 : r_regs[rs2];

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    // Forward only a write that will actually commit on the coming edge:
    // out of reset, enabled, and not targeting x0.
    assign w_fwd1 = rst && rd_enable && (rd != '0) && (rs1 == rd);
    assign w_fwd2 = rst && rd_enable && (rd != '0) && (rs2 == rd);

    assign rs1_data = w_fwd1 ? rd_data : w_rs1_stored;
    assign rs2_data = w_fwd2 ? rd_data : w_rs2_stored;
`else
    assign rs1_data = w_rs1_stored;
    assign rs2_data = w_rs2_stored;
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Directed self-checking bench for register_file.
//                Expected values for the same-cycle read/write case follow
//                the REGFILE_BYPASS_EN macro so the bench suits either
//                build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    logic                  clk;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_enable;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    int errors;
    int checks;

    register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .rd_data   (rd_data),
        .rd_enable (rd_enable),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                         input logic [DATA_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single write cycle: set up at negedge, commit on the following posedge.
    task automatic write_reg(input logic [ADDR_WIDTH-1:0] idx,
                             input logic [DATA_WIDTH-1:0] val);
        @(negedge clk);
        rd        = idx;
        rd_data   = val;
        rd_enable = 1'b1;
        @(posedge clk);
        #1;
        rd_enable = 1'b0;
    endtask

    logic [DATA_WIDTH-1:0] exp_bypass;

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        rs1       = '0;
        rs2       = '0;
        rd        = '0;
        rd_data   = '0;
        rd_enable = 1'b0;

        // Reset held: every index reads zero on both ports.
        #2;
        for (int i = 0; i < 32; i++) begin
            rs1 = ADDR_WIDTH'(i);
            rs2 = ADDR_WIDTH'(31 - i);
            #1;
            check($sformatf("reset_rs1_%0d", i), rs1_data, 32'h0);
            check($sformatf("reset_rs2_%0d", 31 - i), rs2_data, 32'h0);
        end

        // Write attempted across a clock edge while in reset is ignored.
        @(negedge clk);
        rd = 5'd5; rd_data = 32'h1111_1111; rd_enable = 1'b1; rs1 = 5'd5;
        @(posedge clk);
        #1;
        check("write_in_reset", rs1_data, 32'h0);
        rd_enable = 1'b0;

        // Release reset with no writes: contents stay zero.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rs1 = 5'd5; rs2 = 5'd31;
        #1;
        check("post_reset_r5", rs1_data, 32'h0);
        check("post_reset_r31", rs2_data, 32'h0);

        // Basic write then read on both ports.
        write_reg(5'd5, 32'hDEAD_BEEF);
        write_reg(5'd31, 32'h1234_5678);
        rs1 = 5'd5; rs2 = 5'd31;
        #1;
        check("rd_r5", rs1_data, 32'hDEAD_BEEF);
        check("rd_r31", rs2_data, 32'h1234_5678);

        // x0 discards writes.
        write_reg(5'd0, 32'hFFFF_FFFF);
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        check("x0_rs1", rs1_data, 32'h0);
        check("x0_rs2", rs2_data, 32'h0);
        rs1 = 5'd5;
        #1;
        check("x0_no_clobber_r5", rs1_data, 32'hDEAD_BEEF);

        // Enable low: register 7 keeps its reset value.
        @(negedge clk);
        rd = 5'd7; rd_data = 32'hA5A5_A5A5; rd_enable = 1'b0;
        @(posedge clk);
        #1;
        rs1 = 5'd7;
        #1;
        check("gated_r7", rs1_data, 32'h0);

        // Both ports on the same index return identical data.
        rs1 = 5'd31; rs2 = 5'd31;
        #1;
        check("same_idx_rs1", rs1_data, 32'h1234_5678);
        check("same_idx_rs2", rs2_data, 32'h1234_5678);

        // Same-cycle read and write of register 3.
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'h0000_0042;
`else
        exp_bypass = 32'h0000_0000;
`endif
        @(negedge clk);
        rs1 = 5'd3; rs2 = 5'd5;
        rd = 5'd3; rd_data = 32'h0000_0042; rd_enable = 1'b1;
        #1;
        check("bypass_pre_edge", rs1_data, exp_bypass);
        check("bypass_other_port", rs2_data, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        rd_enable = 1'b0;
        #1;
        check("bypass_post_edge", rs1_data, 32'h0000_0042);

        // Asynchronous reset between edges clears immediately.
        @(negedge clk);
        rs1 = 5'd5; rs2 = 5'd31;
        #1;
        check("pre_async_r5", rs1_data, 32'hDEAD_BEEF);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_r5", rs1_data, 32'h0);
        check("async_rst_r31", rs2_data, 32'h0);

        // No forwarding while in reset, and the write never commits.
        rs1 = 5'd3; rd = 5'd3; rd_data = 32'h0000_0099; rd_enable = 1'b1;
        #1;
        check("no_bypass_in_reset", rs1_data, 32'h0);
        @(posedge clk);
        #1;
        check("write_in_reset_r3", rs1_data, 32'h0);

        // First write lands on the first edge after release.
        @(negedge clk);
        rst = 1'b1;
        rd = 5'd9; rd_data = 32'h0BAD_F00D; rd_enable = 1'b1;
        @(posedge clk);
        #1;
        rd_enable = 1'b0;
        rs1 = 5'd9; rs2 = 5'd3;
        #1;
        check("first_write_r9", rs1_data, 32'h0BAD_F00D);
        check("after_reset_r3", rs2_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
